// File: rtl/matrix_uart_printer.sv
// ---------------------------------------------------------------------------
// matrix_uart_printer
//   Prints an m x n matrix of unsigned bytes as ASCII decimal text over a
//   valid/ready byte stream. Elements are read row-major from a synchronous
//   storage port (read data one cycle after the strobe). Elements are
//   separated by a space, and every row ends with CR LF. A one-cycle done
//   pulse follows the final LF (it serves as uart_tx_done).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request; ignored while a print is running
//   dim_m, dim_n          row / column count (legal range 1..MAX_DIM)
//   base_addr             storage address of element (0,0)
//   mem_rd_en, mem_addr   storage read strobe and address
//   mem_rdata             storage read data (one cycle after mem_rd_en)
//   tx_data, tx_valid     byte offered to the UART transmitter
//   tx_ready              transmitter accepts tx_data when high with tx_valid
//   busy                  print in progress
//   done                  one-cycle completion pulse
// ---------------------------------------------------------------------------
module matrix_uart_printer #(
  parameter int ADDR_W  = 6,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0]        MAX_DIM_C = MAX_DIM[2:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_WAIT     = 4'd2,
    ST_CONV     = 4'd3,
    ST_SEND_DIG = 4'd4,
    ST_SEND_SP  = 4'd5,
    ST_SEND_CR  = 4'd6,
    ST_SEND_LF  = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  state_t            state_r;
  logic [2:0]        m_r;
  logic [2:0]        n_r;
  logic [2:0]        row_r;
  logic [2:0]        col_r;
  logic [7:0]        val_r;
  logic [1:0]        dig_idx_r;     // 0 = hundreds, 1 = tens, 2 = ones
  logic              mem_rd_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        tx_data_r;
  logic              tx_valid_r;
  logic              busy_r;
  logic              done_r;

  logic              legal_s;
  logic [11:0]       bcd_s;         // {hundreds, tens, ones}

  // Splits a byte into three BCD digits using compare/subtract steps only.
  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    logic [7:0] rem;
    logic [3:0] hun;
    logic [3:0] ten;
    rem = v;
    ten = 4'd0;
    if (rem >= 8'd200) begin
      hun = 4'd2;
      rem = rem - 8'd200;
    end else if (rem >= 8'd100) begin
      hun = 4'd1;
      rem = rem - 8'd100;
    end else begin
      hun = 4'd0;
    end
    // Remainder is now below 100, so at most nine tens can be removed.
    for (int i = 0; i < 9; i++) begin
      if (rem >= 8'd10) begin
        ten = ten + 4'd1;
        rem = rem - 8'd10;
      end else begin
        ten = ten;
      end
    end
    return {hun, ten, rem[3:0]};
  endfunction

  // ASCII code of the digit at position idx of a BCD triple.
  function automatic logic [7:0] dig_ascii(input logic [11:0] bcd, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = bcd[11:8];
      2'd1:    d = bcd[7:4];
      default: d = bcd[3:0];
    endcase
    return 8'h30 + {4'h0, d};
  endfunction

  // Dimension legality and digit split of the latched element.
  always_comb begin
    legal_s = (dim_m != 3'd0) && (dim_n != 3'd0) &&
              (dim_m <= MAX_DIM_C) && (dim_n <= MAX_DIM_C);
    bcd_s   = to_bcd(val_r);
  end

  // Print sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      m_r         <= 3'd0;
      n_r         <= 3'd0;
      row_r       <= 3'd0;
      col_r       <= 3'd0;
      val_r       <= 8'd0;
      dig_idx_r   <= 2'd0;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      tx_data_r   <= 8'd0;
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            m_r    <= dim_m;
            n_r    <= dim_n;
            row_r  <= 3'd0;
            col_r  <= 3'd0;
            if (legal_s) begin
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= base_addr;
              state_r     <= ST_FETCH;
            end else begin
              // DONE raises the pulse one cycle later, giving busy its single cycle.
              state_r <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          mem_rd_en_r <= 1'b0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          val_r   <= mem_rdata;
          state_r <= ST_CONV;
        end
        ST_CONV: begin
          // Skip leading zeros; a zero value still prints its ones digit.
          if (bcd_s[11:8] != 4'd0) begin
            dig_idx_r <= 2'd0;
            tx_data_r <= dig_ascii(bcd_s, 2'd0);
          end else if (bcd_s[7:4] != 4'd0) begin
            dig_idx_r <= 2'd1;
            tx_data_r <= dig_ascii(bcd_s, 2'd1);
          end else begin
            dig_idx_r <= 2'd2;
            tx_data_r <= dig_ascii(bcd_s, 2'd2);
          end
          tx_valid_r <= 1'b1;
          state_r    <= ST_SEND_DIG;
        end
        ST_SEND_DIG: begin
          if (tx_ready) begin
            if (dig_idx_r != 2'd2) begin
              dig_idx_r <= dig_idx_r + 2'd1;
              tx_data_r <= dig_ascii(bcd_s, dig_idx_r + 2'd1);
            end else if (col_r != (n_r - 3'd1)) begin
              tx_data_r <= 8'h20;
              state_r   <= ST_SEND_SP;
            end else begin
              tx_data_r <= 8'h0D;
              state_r   <= ST_SEND_CR;
            end
          end else begin
            state_r <= ST_SEND_DIG;
          end
        end
        ST_SEND_SP: begin
          if (tx_ready) begin
            tx_valid_r  <= 1'b0;
            col_r       <= col_r + 3'd1;
            mem_addr_r  <= mem_addr_r + ADDR_ONE;
            mem_rd_en_r <= 1'b1;
            state_r     <= ST_FETCH;
          end else begin
            state_r <= ST_SEND_SP;
          end
        end
        ST_SEND_CR: begin
          if (tx_ready) begin
            tx_data_r <= 8'h0A;
            state_r   <= ST_SEND_LF;
          end else begin
            state_r <= ST_SEND_CR;
          end
        end
        ST_SEND_LF: begin
          if (tx_ready) begin
            tx_valid_r <= 1'b0;
            col_r      <= 3'd0;
            if (row_r == (m_r - 3'd1)) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              // Row-major storage: the next row's first element follows the last one.
              row_r       <= row_r + 3'd1;
              mem_addr_r  <= mem_addr_r + ADDR_ONE;
              mem_rd_en_r <= 1'b1;
              state_r     <= ST_FETCH;
            end
          end else begin
            state_r <= ST_SEND_LF;
          end
        end
        ST_DONE: begin
          if (done_r) begin
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_rd_en_r <= 1'b0;
          tx_valid_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = mem_addr_r;
  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: doc/matrix_uart_printer.md
Name: matrix_uart_printer

Overview:
- Handles the DISPLAY_PRINT state and generates uart_tx_done for the central controller.
- On a start pulse it reads an m×n matrix of unsigned 8-bit elements from matrix storage in row-major order.
- It formats each element as ASCII decimal text and streams the bytes to the UART transmitter over a valid/ready byte handshake.
- It pulses done after the final byte is accepted.

Parameters:
- ADDR_W, 6, width of the matrix storage address; address arithmetic wraps modulo 2^ADDR_W.
- MAX_DIM, 5, largest legal value of dim_m and dim_n.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a print; ignored while busy=1.
- dim_m  input  3  row count; sampled on start.
- dim_n  input  3  column count; sampled on start.
- base_addr  input  ADDR_W  address of element (0,0); sampled on start.
- mem_rd_en  output  1  storage read strobe.
- mem_addr  output  ADDR_W  storage read address.
- mem_rdata  input  8  read data, valid exactly 1 cycle after the mem_rd_en cycle.
- tx_data  output  8  ASCII byte to the UART transmitter.
- tx_valid  output  1  tx_data holds a byte for transfer.
- tx_ready  input  1  UART transmitter can accept a byte.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; drives uart_tx_done.

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low. On reset, all outputs are 0, the FSM is in IDLE and the row/column counters are 0.
- Output format, per row: elements separated by a single 0x20 (space); no separator after the last element; each row ends with 0x0D then 0x0A.
- Element text: unsigned decimal 0..255 with no leading zeros, giving 1–3 digits. Value 0 prints as "0".
- Element address: base_addr + r*dim_n + c, truncated to ADDR_W bits. Order is r = 0..m-1 outer, c = 0..n-1 inner.
- States:
  - IDLE → FETCH on start with legal dimensions.
  - FETCH: assert mem_rd_en for 1 cycle with mem_addr → WAIT.
  - WAIT: latch mem_rdata → CONV.
  - CONV: 1 cycle; compute hundreds, tens and ones digits by a subtract/compare chain (no divider); select the first non-zero digit, or the ones digit if the value is 0 → SEND_DIG.
  - SEND_DIG: send the digits MSB-first; after the last digit:
    - → SEND_SP if c < n-1;
    - → SEND_CR otherwise.
  - SEND_SP → FETCH (next column).
  - SEND_CR → SEND_LF.
  - SEND_LF → FETCH (next row), or → DONE after the last row.
  - DONE: done=1 for 1 cycle → IDLE.
- Handshake:
  - A byte transfers on a clk edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable; no byte may be dropped or changed.
  - After a transfer, tx_valid may stay high with the next byte on the following cycle (within SEND_DIG), or drop while the FSM fetches.
  - tx_valid never depends combinationally on tx_ready.
- Latency with tx_ready held at 1:
  - start at cycle 0; mem_rd_en at cycle 1; first tx_valid at cycle 4.
  - done asserts in the cycle after the final LF transfer.
- Illegal dimensions (dim_m=0, dim_n=0, or either > MAX_DIM):
  - no memory reads and no bytes sent;
  - busy=1 for 1 cycle, then done=1 in cycle 2 after start.
- start while busy: ignored. It has no effect on the in-flight stream or the latched dims.
- Inputs dim_m, dim_n and base_addr may change after start without effect.
- Reset mid-transfer: tx_valid, mem_rd_en, busy and done clear immediately (asynchronously). No done pulse is generated; the next start begins a fresh print.
- Byte count for an m×n matrix: m*(n-1) spaces + 2m line-end bytes + total digit count.

Test Plan:
- 2×3 matrix, base 0, contents [1,23,255;0,9,100], tx_ready=1 → byte stream 31 20 32 33 20 32 35 35 0D 0A 30 20 39 20 31 30 30 0D 0A, then exactly one done pulse. Reads occur at addresses 0..5 in order.
- 1×1 matrix, value 0, base_addr=63 → read address 63, bytes 30 0D 0A, then done.
- Same 2×3 stream with tx_ready toggling 1-in-3 and a 10-cycle low stretch → identical byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0.
- start with dim_m=0, then start with dim_n=6 → no mem_rd_en and no tx_valid; done at cycle 2 after each start.
- Second start pulse with different dims during a 5×5 print → output unaffected: 25 elements and 5 CR/LF pairs.
- rst_n low after the 4th byte of a 2×3 print → all outputs 0 in the same cycle. A new start after release prints the full stream from the first byte.
